// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and bin-order helper for the FFT bin reader.
package fft_pkg;
  localparam int FFT_N = 8;
  localparam int FFT_W = 9;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  function automatic logic [SEL_W-1:0] bitrev3(input logic [SEL_W-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction
endpackage

// File: rtl/fft_bin_buf.sv
// Frame buffer: DEPTH x DW register file, one synchronous write port, one async read port.
// Contents are not reset; every entry is rewritten before it is read in a frame.
module fft_bin_buf
  import fft_pkg::*;
#(
  parameter int DEPTH = FFT_N,
  parameter int DW    = 2 * FFT_W,
  parameter int AW    = SEL_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdat,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdat
);
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdat;
  end

  assign o_rdat = r_mem[i_raddr];
endmodule

// File: rtl/fft_bin_reader.sv
// Sweeps the FFT core's bin select, buffers all 8 bins, then streams them out on valid/ready.
// With BITREV_EN defined the sweep is bit-reversed; output order stays natural either way.
module fft_bin_reader
  import fft_pkg::*;
#(
  parameter int N          = FFT_N,
  parameter int W          = FFT_W,
  parameter int SAMPLE_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [SEL_W-1:0] sel,
  input  logic [W-1:0]     yr,
  input  logic [W-1:0]     yi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_re,
  output logic [W-1:0]     out_im,
  output logic [SEL_W-1:0] out_idx,
  output logic             out_last
);
  localparam logic [3:0] LAT      = 4'(SAMPLE_LAT);
  localparam logic [3:0] LAST_CNT = 4'(SAMPLE_LAT + 7);

  state_t           r_state;
  logic [SEL_W-1:0] r_k;
  logic [3:0]       r_cnt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_vld;
  logic             r_last;

  logic [SEL_W-1:0] w_k_inc;
  logic [SEL_W-1:0] w_cap_pos;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [SEL_W-1:0] w_waddr;
  logic             w_we;
  logic             w_hs;
  logic [2*W-1:0]   w_rdat;

  assign w_k_inc   = r_k + 3'd1;
  // Scan position whose data is arriving now: k delayed by the core's sample latency.
  assign w_cap_pos = 3'(r_cnt - LAT);

`ifdef BITREV_EN
  assign w_sel_nxt = bitrev3(w_k_inc);
  assign w_waddr   = bitrev3(w_cap_pos);
`else
  assign w_sel_nxt = w_k_inc;
  assign w_waddr   = w_cap_pos;
`endif

  assign w_we = (r_state == SCAN) && (r_cnt >= LAT);
  assign w_hs = r_vld && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sel <= '0;
          if (start) begin
            r_state <= SCAN;
            r_busy  <= 1'b1;
            r_k     <= '0;
            r_cnt   <= '0;
          end
        end
        SCAN: begin
          if (r_k != 3'd7) begin
            r_k   <= w_k_inc;
            r_sel <= w_sel_nxt;
          end
          if (r_cnt == LAST_CNT) begin
            r_state <= DRAIN;
            r_vld   <= 1'b1;
            r_idx   <= '0;
            r_last  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DRAIN: begin
          if (w_hs) begin
            if (r_idx == 3'd7) begin
              r_state <= IDLE;
              r_vld   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_idx   <= '0;
              r_last  <= 1'b0;
              r_sel   <= '0;
            end else begin
              r_idx  <= r_idx + 3'd1;
              r_last <= (r_idx == 3'd6);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fft_bin_buf #(.DEPTH(N), .DW(2 * W), .AW(SEL_W)) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdat  ({yr, yi}),
    .i_raddr (r_idx),
    .o_rdat  (w_rdat)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign sel       = r_sel;
  assign out_valid = r_vld;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  // Gate the async read so data outputs read zero outside DRAIN (buffer is not reset).
  assign out_re    = r_vld ? w_rdat[2*W-1:W] : '0;
  assign out_im    = r_vld ? w_rdat[W-1:0]   : '0;
endmodule

// File: tb/tb_fft_bin_reader.sv
// Scoreboard bench for fft_bin_reader with a stub FFT core of configurable sample latency.
module tb_fft_bin_reader;
`ifdef BITREV_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, start, out_ready;
  logic       busy, done, out_valid, out_last;
  logic [2:0] sel, out_idx;
  logic [8:0] yr, yi, out_re, out_im;

  always #5 clk = ~clk;

  fft_bin_reader #(.N(8), .W(9), .SAMPLE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .sel(sel),
    .yr(yr), .yi(yi), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] f_re(input int m, input int b);
    case (m)
      0:       return 9'(b * 10);
      1:       return 9'd255;
      default: return 9'(b * 17 - 60);
    endcase
  endfunction

  function automatic logic [8:0] f_im(input int m, input int b);
    case (m)
      0:       return 9'(-b);
      1:       return 9'h100;
      default: return 9'(100 - 29 * b);
    endcase
  endfunction

  function automatic logic [2:0] order(input int j);
    logic [2:0] v;
    v = 3'(j > 7 ? 7 : j);
`ifdef BITREV_EN
    return {v[0], v[1], v[2]};
`else
    return v;
`endif
  endfunction

  // Stub core: bin data appears LAT clocks after sel changes.
  int         mode = 0;
  logic [2:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= sel;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign yr = f_re(mode, int'(pipe[LAT-1]));
  assign yi = f_im(mode, int'(pipe[LAT-1]));

  int         rdy_mode = 0;
  logic [3:0] rdy_pat  = 4'b1001;
  initial begin
    out_ready = 1'b1;
    for (int rc = 0; ; rc++) begin
      @(posedge clk);
      #2;
      out_ready = (rdy_mode == 0) ? 1'b1 : rdy_pat[rc % 4];
    end
  end

  typedef struct {
    int         idx;
    logic [8:0] re;
    logic [8:0] im;
    logic       last;
  } exp_t;

  exp_t q[$];
  bit   chk_en   = 0;
  bit   exp_done = 0;
  int   done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      chk("done", done, exp_done);
      exp_done = 0;
      if (done) done_cnt++;
      if (out_valid) begin
        chk("beat_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q[0];
          chk("out_idx", out_idx, e.idx);
          chk("out_re", out_re, e.re);
          chk("out_im", out_im, e.im);
          chk("out_last", out_last, e.last);
          if (out_ready) begin
            void'(q.pop_front());
            if (e.last) exp_done = 1;
          end
        end
      end
    end
  end

  task automatic run_frame(input int m, input bit noise);
    int cyc;
    int dn0;
    int j;
    mode = m;
    dn0  = done_cnt;
    for (int b = 0; b < 8; b++) q.push_back('{idx: b, re: f_re(m, b), im: f_im(m, b), last: (b == 7)});
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start = 1'b0;
    while (!out_valid && cyc < 40) begin
      chk("scan_sel", sel, order(cyc - 1));
      chk("scan_busy", busy, 1);
      start = (noise && cyc == 4);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("first_valid_latency", cyc, 9 + LAT);
    j = 0;
    while (done_cnt == dn0 && j < 300) begin
      start = (noise && j == 3);
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    chk("frame_done_count", done_cnt - dn0, 1);
    chk("queue_drained", q.size(), 0);
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_sel", sel, 0);
    chk("single_done", done_cnt - dn0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_sel", sel, 0);
    chk("rst_re", out_re, 0);
    chk("rst_im", out_im, 0);
    chk("rst_idx", out_idx, 0);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1;

    rdy_mode = 0; run_frame(0, 0);
    rdy_mode = 1; run_frame(2, 0);
    rdy_mode = 0; run_frame(1, 0);
    run_frame(2, 1);

    // Abort a frame mid-scan at k=4.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_sel", sel, order(4));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_sel", sel, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_idle_valid", out_valid, 0);

    rdy_mode = 1; run_frame(0, 1);
    rdy_mode = 0; run_frame(2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
